// File: rtl/instr_queue.sv
// instr_queue: circular FIFO of fetched {pc, instr} pairs between fetch and decode.
//
// The oldest entry is presented first-word-fall-through on pc_to_dc/instr_to_dc.
// A flush from the ROB discards every entry in one cycle.
//
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous active-low reset
//   valid_from_fetch  fetch offers {pc_from_fetch, instr_from_fetch} this cycle
//   pc_from_fetch     pc of the offered instruction
//   instr_from_fetch  raw instruction word
//   is_full_to_fetch  queue holds Depth entries; an offer now is dropped
//   rdy_from_dc       decoder consumes the head entry this cycle
//   clr_from_rob      flush: discard all entries (wins over push and pop)
//   is_empty_to_dc    queue holds no entries
//   pc_to_dc          pc of the head entry (0 when empty)
//   instr_to_dc       instruction word of the head entry (0 when empty)
//   cnt               current occupancy, 0..Depth
module instr_queue #(
    parameter int unsigned Depth     = 16,
    parameter int unsigned AddrWidth = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_from_fetch,
    input  logic [31:0]          pc_from_fetch,
    input  logic [31:0]          instr_from_fetch,
    output logic                 is_full_to_fetch,
    input  logic                 rdy_from_dc,
    input  logic                 clr_from_rob,
    output logic                 is_empty_to_dc,
    output logic [31:0]          pc_to_dc,
    output logic [31:0]          instr_to_dc,
    output logic [AddrWidth:0]   cnt
);

    localparam logic [AddrWidth:0] FullCnt = (AddrWidth + 1)'(Depth);

    logic [AddrWidth-1:0] head_q, head_d;
    logic [AddrWidth-1:0] tail_q, tail_d;
    logic [AddrWidth:0]   cnt_q, cnt_d;

    logic [31:0] pc_mem    [Depth];
    logic [31:0] instr_mem [Depth];

    logic empty, full, push, pop;

    // Flags come from the registered count only, so no input reaches them combinationally.
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FullCnt);

    assign push = valid_from_fetch && !full;
    assign pop  = rdy_from_dc && !empty;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (clr_from_rob) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is deliberately not reset; the head outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push && !clr_from_rob) begin
            pc_mem[tail_q]    <= pc_from_fetch;
            instr_mem[tail_q] <= instr_from_fetch;
        end
    end

    assign pc_to_dc         = empty ? 32'h0 : pc_mem[head_q];
    assign instr_to_dc      = empty ? 32'h0 : instr_mem[head_q];
    assign is_empty_to_dc   = empty;
    assign is_full_to_fetch = full;
    assign cnt              = cnt_q;

endmodule
